// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter. The CPU owns every cycle with cpu_clken=1. A one-entry
// DMA buffer is issued to the RAM in free cycles (cpu_clken=0).
module ram_arbiter #(
    parameter int ADDR_W = 16
) (
    input  logic              sys_clock,
    input  logic              reset_n,
    input  logic              cpu_clken,
    // CPU side
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_dout,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    output logic [7:0]        cpu_din,
    // DMA side
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [7:0]        dma_wdata,
    output logic              dma_ack,
    output logic [7:0]        dma_rdata,
    output logic              dma_rvalid,
    output logic              dma_busy,
    // RAM side
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    input  logic [7:0]        ram_dout,
    output logic              ram_rd,
    output logic              ram_wr
);

    typedef enum logic [1:0] {
        IDLE,
        DMA_WR,
        DMA_RD,
        DMA_RWAIT
    } state_t;

    state_t            state, state_next;
    logic              buf_full;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_data;
    logic              req_armed;
    logic              buf_free;
    logic              accept;
    logic              dma_issue;

    // The buffer is released in the final cycle of each access, so a waiting
    // requester can be accepted in that same cycle.
    assign buf_free  = (state == DMA_WR) || (state == DMA_RWAIT);
    assign accept    = dma_req && req_armed && (!buf_full || buf_free);
    assign dma_issue = (state == IDLE) && buf_full && !cpu_clken;

    assign dma_ack    = accept;
    assign dma_rvalid = (state == DMA_RWAIT);
    assign dma_busy   = buf_full || (state != IDLE);
    assign cpu_din    = ram_dout;

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_next = state;
        ram_addr   = cpu_addr;
        ram_din    = cpu_dout;
        ram_rd     = 1'b0;
        ram_wr     = 1'b0;

        if (cpu_clken) begin
            ram_rd = cpu_rd;
            ram_wr = cpu_wr;
        end else if (dma_issue) begin
            ram_addr = buf_addr;
            ram_din  = buf_data;
            ram_rd   = !buf_we;
            ram_wr   = buf_we;
        end

        case (state)
            IDLE:      if (dma_issue) state_next = buf_we ? DMA_WR : DMA_RD;
            DMA_WR:    state_next = IDLE;
            DMA_RD:    state_next = DMA_RWAIT;
            DMA_RWAIT: state_next = IDLE;
        endcase

        // Strobes must not reach the RAM while reset is held.
        if (!reset_n) begin
            ram_rd = 1'b0;
            ram_wr = 1'b0;
        end
    end

    // The RAM returns DMA read data in the cycle after issue (DMA_RD). It is
    // captured there, before a CPU read in that cycle can replace it.
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            buf_full  <= 1'b0;
            req_armed <= 1'b0;
            dma_rdata <= 8'h00;
        end else begin
            if (!dma_req) begin
                req_armed <= 1'b1;
            end
            if (accept) begin
                buf_full <= 1'b1;
            end else if (buf_free) begin
                buf_full <= 1'b0;
            end
            if (state == DMA_RD) begin
                dma_rdata <= ram_dout;
            end
        end
    end

    // NOTE: the payload is not reset; it is only read while buf_full is set,
    // and buf_full always is reset.
    always_ff @(posedge sys_clock) begin
        if (accept) begin
            buf_we   <= dma_we;
            buf_addr <= dma_addr;
            buf_data <= dma_wdata;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a behavioural RAM with one-cycle read latency, a
// table of CPU pass-through vectors, and directed multi-cycle DMA sequences.
module tb_ram_arbiter;

    localparam int ADDR_W = 16;

    logic              sys_clock = 1'b0;
    logic              reset_n;
    logic              cpu_clken;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_dout;
    logic              cpu_rd;
    logic              cpu_wr;
    logic [7:0]        cpu_din;
    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [7:0]        dma_wdata;
    logic              dma_ack;
    logic [7:0]        dma_rdata;
    logic              dma_rvalid;
    logic              dma_busy;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;
    logic              ram_rd;
    logic              ram_wr;

    logic              pre_we;
    logic [ADDR_W-1:0] pre_addr;
    logic [7:0]        pre_data;
    logic [7:0]        mem [0:(1<<ADDR_W)-1];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 sys_clock = ~sys_clock;

    ram_arbiter #(.ADDR_W(ADDR_W)) dut (
        .sys_clock (sys_clock),
        .reset_n   (reset_n),
        .cpu_clken (cpu_clken),
        .cpu_addr  (cpu_addr),
        .cpu_dout  (cpu_dout),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_din   (cpu_din),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_ack   (dma_ack),
        .dma_rdata (dma_rdata),
        .dma_rvalid(dma_rvalid),
        .dma_busy  (dma_busy),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .ram_rd    (ram_rd),
        .ram_wr    (ram_wr)
    );

    // Synchronous RAM, one-cycle read latency, plus a preload port for the bench.
    always @(posedge sys_clock) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_wr) begin
            mem[ram_addr] <= ram_din;
        end
        if (ram_rd) begin
            ram_dout <= mem[ram_addr];
        end
    end

    typedef struct {
        logic              clken;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        dout;
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] exp_addr;
        logic [7:0]        exp_din;
        logic              exp_rd;
        logic              exp_wr;
        logic              chk_addr;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic to_neg();
        @(negedge sys_clock);
    endtask

    task automatic to_next();
        @(posedge sys_clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cyc;
        int dma_wr_cnt;
        int clash;
        int bad_ack;
        int bad_cpu;
        int bad_mem;
        logic acked;

        vecs[0] = '{1'b1, 16'h1234, 8'hA5, 1'b1, 1'b0, 16'h1234, 8'hA5, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 16'hBEEF, 8'h3C, 1'b0, 1'b1, 16'hBEEF, 8'h3C, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 16'h4321, 8'h99, 1'b1, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 16'h00FF, 8'h00, 1'b0, 1'b0, 16'h00FF, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 16'hFFFF, 8'hFF, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 16'hFFFE, 8'hC3, 1'b1, 1'b1, 16'hFFFE, 8'hC3, 1'b1, 1'b1, 1'b1};

        // Reset with hostile inputs: CPU write strobe and DMA request both high.
        reset_n   = 1'b0;
        cpu_clken = 1'b1;
        cpu_addr  = 16'h0001;
        cpu_dout  = 8'hEE;
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b1;
        dma_req   = 1'b1;
        dma_we    = 1'b1;
        dma_addr  = 16'h0002;
        dma_wdata = 8'h00;
        pre_we    = 1'b0;
        pre_addr  = '0;
        pre_data  = '0;
        to_neg();
        check("reset_ram_wr", ram_wr, 0);
        check("reset_dma_ack", dma_ack, 0);
        check("reset_rvalid", dma_rvalid, 0);
        check("reset_rdata", dma_rdata, 8'h00);
        check("reset_busy", dma_busy, 0);
        to_next();

        cpu_wr  = 1'b0;
        dma_req = 1'b0;
        pre_we  = 1'b1;
        pre_addr = 16'h1000; pre_data = 8'h11; to_next();
        pre_addr = 16'hFF00; pre_data = 8'hD8; to_next();
        pre_we  = 1'b0;
        reset_n = 1'b1;
        to_next();

        // CPU pass-through table, DMA idle.
        for (int i = 0; i < 6; i++) begin
            cpu_clken = vecs[i].clken;
            cpu_addr  = vecs[i].addr;
            cpu_dout  = vecs[i].dout;
            cpu_rd    = vecs[i].rd;
            cpu_wr    = vecs[i].wr;
            to_neg();
            if (vecs[i].chk_addr) begin
                check($sformatf("vec%0d_ram_addr", i), ram_addr, vecs[i].exp_addr);
                check($sformatf("vec%0d_ram_din", i), ram_din, vecs[i].exp_din);
            end
            check($sformatf("vec%0d_ram_rd", i), ram_rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_ram_wr", i), ram_wr, vecs[i].exp_wr);
            check($sformatf("vec%0d_cpu_din", i), cpu_din, ram_dout);
            check($sformatf("vec%0d_dma_ack", i), dma_ack, 0);
            to_next();
        end
        cpu_clken = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        to_next();

        // DMA write 0x0280<-0x5A, then read it back, CPU absent.
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0280; dma_wdata = 8'h5A;
        to_neg();
        check("wr_ack", dma_ack, 1);
        check("wr_no_early_strobe", ram_wr, 0);
        to_next();
        dma_req = 1'b0;
        to_neg();
        check("wr_strobe", ram_wr, 1);
        check("wr_addr", ram_addr, 16'h0280);
        check("wr_data", ram_din, 8'h5A);
        check("wr_busy", dma_busy, 1);
        to_next();
        dma_req = 1'b1; dma_we = 1'b0;
        to_neg();
        check("rd_ack_b2b", dma_ack, 1);
        check("wr_single_pulse", ram_wr, 0);
        to_next();
        dma_req = 1'b0;
        to_neg();
        check("rd_strobe", ram_rd, 1);
        check("rd_addr", ram_addr, 16'h0280);
        to_next();
        to_neg();
        check("rd_rvalid_early", dma_rvalid, 0);
        to_next();
        to_neg();
        check("rd_rvalid", dma_rvalid, 1);
        check("rd_rdata", dma_rdata, 8'h5A);
        to_next();
        to_neg();
        check("rd_rvalid_pulse", dma_rvalid, 0);
        check("rd_rdata_hold", dma_rdata, 8'h5A);
        check("rd_idle_busy", dma_busy, 0);
        to_next();

        // CPU owns 10 consecutive cycles while DMA waits; the second request is held unacked.
        cpu_clken = 1'b1; cpu_wr = 1'b1; cpu_addr = 16'h2000; cpu_dout = 8'h40;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h3000; dma_wdata = 8'h77;
        to_neg();
        check("pend_ack", dma_ack, 1);
        check("pend_cpu_wr", ram_wr, 1);
        check("pend_cpu_addr", ram_addr, 16'h2000);
        to_next();
        dma_addr = 16'h3001; dma_wdata = 8'h78;
        bad_ack = 0;
        bad_cpu = 0;
        for (int i = 1; i < 10; i++) begin
            cpu_addr = 16'h2000 + 16'(i);
            cpu_dout = 8'h40 + 8'(i);
            to_neg();
            if (dma_ack !== 1'b0) bad_ack++;
            if (ram_addr !== cpu_addr || ram_din !== cpu_dout || ram_wr !== 1'b1) bad_cpu++;
            to_next();
        end
        check("pend_full_ack_cycles", bad_ack, 0);
        check("pend_cpu_cycles_disturbed", bad_cpu, 0);
        cpu_clken = 1'b0; cpu_wr = 1'b0;
        to_neg();
        check("pend_issue_wr", ram_wr, 1);
        check("pend_issue_addr", ram_addr, 16'h3000);
        check("pend_issue_data", ram_din, 8'h77);
        check("pend_issue_ack", dma_ack, 0);
        to_next();
        to_neg();
        check("held_req_ack", dma_ack, 1);
        to_next();
        dma_req = 1'b0;
        to_neg();
        check("held_issue_addr", ram_addr, 16'h3001);
        check("held_issue_wr", ram_wr, 1);
        to_next();
        to_next();
        to_neg();
        check("pend_done_busy", dma_busy, 0);
        to_next();
        check("pend_mem_3000", mem[16'h3000], 8'h77);
        check("pend_mem_3001", mem[16'h3001], 8'h78);
        bad_mem = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem[16'h2000 + 16'(i)] !== 8'h40 + 8'(i)) bad_mem++;
        end
        check("pend_cpu_mem", bad_mem, 0);

        // 8 DMA writes interleaved with CPU writes, cpu_clken pattern 1,0,0,0.
        n = 0; cyc = 0; dma_wr_cnt = 0; clash = 0;
        while (cyc < 200 && !(n == 8 && !dma_busy)) begin
            cpu_clken = (cyc % 4 == 0);
            cpu_wr    = cpu_clken;
            cpu_rd    = 1'b0;
            cpu_addr  = 16'h5000 + 16'(cyc);
            cpu_dout  = 8'(cyc);
            dma_req   = (n < 8);
            dma_we    = 1'b1;
            dma_addr  = 16'h4000 + 16'(3 * n);
            dma_wdata = 8'h90 + 8'(n);
            to_neg();
            acked = dma_ack;
            if (cpu_clken) begin
                if (ram_addr !== cpu_addr || ram_din !== cpu_dout || ram_wr !== 1'b1 || ram_rd !== 1'b0) clash++;
            end else begin
                if (ram_rd !== 1'b0) clash++;
                if (ram_wr === 1'b1) dma_wr_cnt++;
            end
            to_next();
            if (acked) n++;
            cyc++;
        end
        cpu_clken = 1'b0; cpu_wr = 1'b0; dma_req = 1'b0;
        check("stream_acks", n, 8);
        check("stream_dma_writes", dma_wr_cnt, 8);
        check("stream_clash", clash, 0);
        bad_mem = 0;
        for (int i = 0; i < 8; i++) begin
            if (mem[16'h4000 + 16'(3 * i)] !== 8'h90 + 8'(i)) bad_mem++;
        end
        check("stream_dma_mem", bad_mem, 0);
        check("stream_cpu_mem", mem[16'h5004], 8'h04);
        to_next();

        // DMA read 0x1000 followed by a CPU read of 0xFF00 in the next cycle.
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h1000;
        to_neg();
        check("mix_ack", dma_ack, 1);
        to_next();
        dma_req = 1'b0;
        to_neg();
        check("mix_dma_rd", ram_rd, 1);
        check("mix_dma_addr", ram_addr, 16'h1000);
        to_next();
        cpu_clken = 1'b1; cpu_rd = 1'b1; cpu_addr = 16'hFF00;
        to_neg();
        check("mix_cpu_addr", ram_addr, 16'hFF00);
        check("mix_cpu_rd", ram_rd, 1);
        to_next();
        cpu_clken = 1'b0; cpu_rd = 1'b0;
        to_neg();
        check("mix_dma_rdata", dma_rdata, 8'h11);
        check("mix_rvalid", dma_rvalid, 1);
        check("mix_cpu_din", cpu_din, 8'hD8);
        to_next();
        to_next();

        // Reset asserted while a DMA read is in DMA_RD.
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h1000;
        to_neg();
        check("rst_rd_ack", dma_ack, 1);
        to_next();
        to_next();
        reset_n = 1'b0;
        to_neg();
        check("rst_mid_rvalid", dma_rvalid, 0);
        check("rst_mid_rdata", dma_rdata, 8'h00);
        check("rst_mid_busy", dma_busy, 0);
        check("rst_mid_ack", dma_ack, 0);
        to_next();
        reset_n = 1'b1;
        bad_ack = 0;
        for (int i = 0; i < 4; i++) begin
            to_neg();
            if (dma_ack !== 1'b0 || dma_rvalid !== 1'b0 || dma_busy !== 1'b0) bad_ack++;
            to_next();
        end
        check("rst_stale_req_ignored", bad_ack, 0);
        dma_req = 1'b0;
        to_next();
        dma_req = 1'b1; dma_addr = 16'hFF00;
        to_neg();
        check("rst_fresh_ack", dma_ack, 1);
        to_next();
        dma_req = 1'b0;
        to_next();
        to_next();
        to_neg();
        check("rst_fresh_rvalid", dma_rvalid, 1);
        check("rst_fresh_rdata", dma_rdata, 8'hD8);
        to_next();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: width of all RAM address buses.
REQ-002 SHALL have port sys_clock, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port cpu_clken, input, 1 bit: CPU clock enable; a CPU RAM slot exists only in cycles where it is 1.
REQ-005 SHALL have CPU-side ports: cpu_addr in ADDR_W; cpu_dout in 8 (write data); cpu_rd in 1; cpu_wr in 1; cpu_din out 8 (read data).
REQ-006 SHALL have DMA-side ports: dma_req in 1; dma_we in 1; dma_addr in ADDR_W; dma_wdata in 8; dma_ack out 1; dma_rdata out 8; dma_rvalid out 1.
REQ-007 SHALL have RAM-side ports: ram_addr out ADDR_W; ram_din out 8; ram_dout in 8; ram_rd out 1; ram_wr out 1; RAM read latency is fixed at one cycle.
REQ-008 SHALL have port dma_busy, output, 1 bit: high while a DMA request is buffered or in flight.

Function
REQ-009 SHALL use states IDLE, DMA_WR, DMA_RD, DMA_RWAIT.
REQ-010 SHALL give the CPU absolute priority: in any cycle with cpu_clken=1, it drives ram_addr=cpu_addr, ram_din=cpu_dout, ram_rd=cpu_rd, ram_wr=cpu_wr&cpu_clken combinationally, with no added latency.
REQ-011 SHALL tie cpu_din directly to ram_dout.
REQ-012 SHALL accept a DMA request into a one-entry buffer (addr, data, we) when dma_req=1 and the buffer is empty, and pulse dma_ack for exactly one cycle in that same cycle.
REQ-013 SHALL hold dma_ack=0 while the buffer is full; the requester keeps dma_req and its operands stable until it sees ack.
REQ-014 SHALL leave IDLE with a full buffer only in a cycle with cpu_clken=0, issuing the DMA access that cycle and entering DMA_WR (we=1) or DMA_RD (we=0).
REQ-015 SHALL drive ram_rd=0 and ram_wr=0 in cycles with cpu_clken=0 and no DMA issue.
REQ-016 SHALL, if a full buffer sees cpu_clken=1, keep the DMA request pending with no loss, retrying on the next cycle where cpu_clken=0.
REQ-017 SHALL, for DMA_WR, drive ram_wr=1 for exactly one cycle, then free the buffer and return to IDLE.
REQ-018 SHALL, for DMA_RD, drive ram_rd=1 for one cycle, then move to DMA_RWAIT; in DMA_RWAIT it registers ram_dout into dma_rdata, pulses dma_rvalid for one cycle, frees the buffer and returns to IDLE.
REQ-019 SHALL not issue a DMA access in DMA_RWAIT; a CPU slot in DMA_RWAIT is still served per REQ-010, and dma_rdata captures the DMA read result, not the CPU one.
REQ-020 SHALL allow a new DMA request to be acked in the same cycle the buffer is freed (back-to-back); a request is issued at most once per cycle with cpu_clken=0.
REQ-021 SHALL hold dma_rdata until the next DMA read completes.
REQ-022 SHALL drive dma_busy = buffer full OR state != IDLE.
REQ-023 SHALL leave address arithmetic to the requesters (no wrap handling); ADDR_W bits pass through unmodified.

Reset
REQ-024 SHALL, on reset_n=0, asynchronously force state=IDLE, buffer empty, dma_ack=0, dma_rvalid=0, dma_rdata=8'h00, dma_busy=0.
REQ-025 SHALL, while in reset, hold ram_wr=0 regardless of CPU inputs.
REQ-026 SHALL drop a pending or in-flight DMA request on reset, with no ack or rvalid after reset release.
REQ-027 SHALL wait for a fresh dma_req after reset release before accepting any DMA request.

Verification
REQ-028 Bench SHALL cover: cpu_clken=0 always, DMA write 0x0280<-0x5A then read 0x0280 -> ram_wr pulses once, then dma_rvalid one cycle later with dma_rdata=0x5A, i.e. 3 cycles from ack.
REQ-029 Bench SHALL cover: cpu_clken=1 continuously for 10 cycles with DMA pending -> no DMA access; DMA is issued in the first cpu_clken=0 cycle; CPU writes are unaffected.
REQ-030 Bench SHALL cover: cpu_clken pattern 1,0,0,0 repeating with a stream of 8 DMA writes -> all 8 land at the correct addresses, and no cycle has both a CPU and a DMA strobe.
REQ-031 Bench SHALL cover: DMA read at 0x1000 (=0x11) issued, CPU reads 0xFF00 (=0xD8) in the next cycle -> dma_rdata=0x11 and cpu_din=0xD8 one cycle later.
REQ-032 Bench SHALL cover: reset_n pulled low during DMA_RD -> outputs take reset values immediately; no dma_rvalid after release; the next request works normally.
REQ-033 Bench SHALL cover: dma_req held while the buffer is full -> dma_ack stays 0 until the buffer is freed, then pulses once.
